// File: rtl/tb_status_periph_if.sv
// Core data-bus port of the simulation status/console responder.
// The master drives the request side; the slave returns grant and response.
interface tb_status_periph_if;
    logic        req_i;
    logic        gnt_o;
    logic [7:0]  addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/tb_status_periph.sv
// Status and console responder: turns software writes into pass/fail/exit
// signals, buffers printed bytes in a FIFO and exposes a free-running cycle counter.
module tb_status_periph #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    tb_status_periph_if.slave   bus,
    output logic                tests_passed_o,
    output logic                tests_failed_o,
    output logic                exit_valid_o,
    output logic [31:0]         exit_value_o,
    output logic                char_valid_o,
    output logic [7:0]          char_o,
    input  logic                char_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [5:0] REG_PRINT = 6'h00;
    localparam logic [5:0] REG_PASS  = 6'h01;
    localparam logic [5:0] REG_FAIL  = 6'h02;
    localparam logic [5:0] REG_EXIT  = 6'h03;
    localparam logic [5:0] REG_CYCLE = 6'h04;

    logic [5:0]           word;
    logic                 print_write;
    logic                 fifo_full;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [PTR_W:0]       level;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [31:0]          read_data;

    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic                 passed_q;
    logic                 failed_q;
    logic                 exit_q;
    logic [31:0]          exit_value_q;
    logic                 unused_bits;

    assign unused_bits = ^{bus.addr_i[1:0], bus.be_i[3:1]};

    assign word        = bus.addr_i[7:2];
    assign print_write = bus.we_i && (word == REG_PRINT);
    assign fifo_full   = (level == FULL_LEVEL);
    assign bus.gnt_o   = bus.req_i && !(print_write && fifo_full);
    assign accept      = bus.req_i && bus.gnt_o;
    assign push        = accept && print_write && bus.be_i[0];
    assign pop         = char_ready_i && (level != '0);

    // A push into a full FIFO cannot happen because such a write is never
    // granted, so push and pop together always leave the level unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.wdata_i[7:0];
    end

    assign char_valid_o = (level != '0);
    assign char_o       = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cycle_cnt <= '0;
        else         cycle_cnt <= cycle_cnt + 1'b1;
    end

    always_comb begin
        read_data = '0;
        if (!bus.we_i) begin
            case (word)
                REG_PRINT: read_data = 32'(level);
                REG_CYCLE: read_data = 32'(cycle_cnt);
                default:   read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_q       <= 1'b0;
            exit_value_q <= '0;
        end else begin
            rvalid_q <= accept;
            rdata_q  <= accept ? read_data : '0;
            passed_q <= accept && bus.we_i && (word == REG_PASS);
            failed_q <= accept && bus.we_i && (word == REG_FAIL);
            exit_q   <= accept && bus.we_i && (word == REG_EXIT);
            if (accept && bus.we_i && (word == REG_EXIT)) exit_value_q <= bus.wdata_i;
        end
    end

    // Masking with rst_ni drops a response that is already registered when
    // reset arrives, so nothing from before reset is seen while it is held.
    assign bus.rvalid_o   = rvalid_q && rst_ni;
    assign bus.rdata_o    = rst_ni ? rdata_q : '0;
    assign tests_passed_o = passed_q && rst_ni;
    assign tests_failed_o = failed_q && rst_ni;
    assign exit_valid_o   = exit_q && rst_ni;
    assign exit_value_o   = exit_value_q;

endmodule
